// File: rtl/counter_timer_if.sv
// Purpose : control/status bundle between the game FSM and counter_timer.
// Latency : none (wires only).
// Backpress: none; go/up/en/abort in, count/busy/done/step/wrap out.
//
// Ports:
//   go, up, en, abort     - controls from the game FSM (master -> slave)
//   count[WIDTH-1:0]      - current count value (slave -> master)
//   busy, done            - state flags (slave -> master)
//   step, wrap            - one-cycle strobes (slave -> master)
interface counter_timer_if #(
  parameter int WIDTH = 14
);
  logic             go;
  logic             up;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             step;
  logic             wrap;

  modport master (
    output go, up, en, abort,
    input  count, busy, done, step, wrap
  );

  modport slave (
    input  go, up, en, abort,
    output count, busy, done, step, wrap
  );
endinterface

// File: rtl/counter_timer.sv
// Purpose : prescaled up/down event counter with stop-at-terminal or wrap mode.
// Latency : count/step/wrap/busy/done all registered, valid one clk after the edge.
// Backpress: en=0 freezes count and prescaler; abort parks in IDLE holding count.
//
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - counter_timer_if slave: go/up/en/abort in, count/busy/done/step/wrap out
module counter_timer #(
  parameter int WIDTH    = 14,
  parameter int MAXCOUNT = 12348,
  parameter int DIV      = 1,
  parameter int WRAP     = 0
) (
  input  logic               clk,
  input  logic               resetn,
  counter_timer_if.slave     bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] LP_MAX      = WIDTH'(MAXCOUNT);
  localparam logic [PW-1:0]    LP_DIV_LAST = PW'(DIV - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_presc;
  logic             r_dir;     // 1 = counting up; latched on go
  logic             r_step;
  logic             r_wrap;

  logic             w_tick;
  logic [WIDTH-1:0] w_start;   // start value for the direction requested on go
  logic [WIDTH-1:0] w_term;    // terminal value for the latched direction
  logic [WIDTH-1:0] w_reload;  // start value for the latched direction

  // With DIV=1 the prescaler is a constant zero, so every enabled cycle ticks.
  assign w_tick   = (r_presc == LP_DIV_LAST);
  assign w_start  = bus.up ? '0 : LP_MAX;
  assign w_term   = r_dir ? LP_MAX : '0;
  assign w_reload = r_dir ? '0 : LP_MAX;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_presc <= '0;
      r_dir   <= 1'b1;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      if (bus.go) begin
        r_dir   <= bus.up;
        r_count <= w_start;
        r_presc <= '0;
        r_state <= S_RUN;
      end else if (r_state == S_RUN) begin
        if (bus.abort) begin
          r_state <= S_IDLE;
        end else if (bus.en) begin
          if (!w_tick) begin
            r_presc <= r_presc + 1'b1;
          end else begin
            r_presc <= '0;
            if (r_count != w_term) begin
              r_count <= r_dir ? (r_count + 1'b1) : (r_count - 1'b1);
              r_step  <= 1'b1;
            end else if (WRAP != 0) begin
              r_count <= w_reload;
              r_step  <= 1'b1;
              r_wrap  <= 1'b1;
            end else begin
              // Terminal was shown for a full tick; only now finish.
              r_state <= S_DONE;
            end
          end
        end
      end
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = (r_state == S_DONE);
  assign bus.step  = r_step;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_counter_timer.sv
// Purpose : self-checking bench for counter_timer over four parameter sets.
// Latency : outputs compared 1 time unit after each rising edge.
// Backpress: all instances share one stimulus stream.
module tb_counter_timer;

  logic clk;
  logic resetn;
  logic go, up, en, abort;

  int total = 0;
  int bad   = 0;

  // Instance parameters: A, B, C, D
  int p_max [4] = '{5, 7, 3, 12348};
  int p_div [4] = '{1, 4, 1, 1};
  int p_wrap[4] = '{0, 0, 1, 0};

  // Reference model: enabled-cycle count since go drives everything else.
  int m_n   [4];
  bit m_run [4];
  bit m_done[4];
  bit m_dir [4];
  bit m_step[4];
  bit m_wrap[4];

  counter_timer_if #(.WIDTH(4))  if0 ();
  counter_timer_if #(.WIDTH(4))  if1 ();
  counter_timer_if #(.WIDTH(2))  if2 ();
  counter_timer_if #(.WIDTH(14)) if3 ();

  assign if0.go = go;  assign if0.up = up;  assign if0.en = en;  assign if0.abort = abort;
  assign if1.go = go;  assign if1.up = up;  assign if1.en = en;  assign if1.abort = abort;
  assign if2.go = go;  assign if2.up = up;  assign if2.en = en;  assign if2.abort = abort;
  assign if3.go = go;  assign if3.up = up;  assign if3.en = en;  assign if3.abort = abort;

  counter_timer #(.WIDTH(4), .MAXCOUNT(5), .DIV(1), .WRAP(0))
    u_a (.clk(clk), .resetn(resetn), .bus(if0));
  counter_timer #(.WIDTH(4), .MAXCOUNT(7), .DIV(4), .WRAP(0))
    u_b (.clk(clk), .resetn(resetn), .bus(if1));
  counter_timer #(.WIDTH(2), .MAXCOUNT(3), .DIV(1), .WRAP(1))
    u_c (.clk(clk), .resetn(resetn), .bus(if2));
  counter_timer #(.WIDTH(14), .MAXCOUNT(12348), .DIV(1), .WRAP(0))
    u_d (.clk(clk), .resetn(resetn), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin
      m_n[i] = 0; m_run[i] = 0; m_done[i] = 0; m_dir[i] = 1;
      m_step[i] = 0; m_wrap[i] = 0;
    end
  endtask

  task automatic medge(input int i);
    int t;
    m_step[i] = 0;
    m_wrap[i] = 0;
    if (go) begin
      m_dir[i] = up; m_n[i] = 0; m_run[i] = 1; m_done[i] = 0;
    end else if (m_run[i]) begin
      if (abort) begin
        m_run[i] = 0;
      end else if (en) begin
        m_n[i] = m_n[i] + 1;
        if (m_n[i] % p_div[i] == 0) begin
          t = m_n[i] / p_div[i];
          if (p_wrap[i] != 0) begin
            m_step[i] = 1;
            m_wrap[i] = (t % (p_max[i] + 1) == 0);
          end else if (t <= p_max[i]) begin
            m_step[i] = 1;
          end else begin
            m_run[i] = 0; m_done[i] = 1;
          end
        end
      end
    end
  endtask

  function automatic int mcount(input int i);
    int t, pos;
    t = m_n[i] / p_div[i];
    if (p_wrap[i] != 0) pos = t % (p_max[i] + 1);
    else                pos = (t > p_max[i]) ? p_max[i] : t;
    return m_dir[i] ? pos : (p_max[i] - pos);
  endfunction

  task automatic expect_eq(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic chk(input int i, input int c, input logic b, input logic d,
                     input logic s, input logic w);
    string n;
    n = $sformatf("%0d", i);
    expect_eq({"count", n}, c, mcount(i));
    expect_eq({"busy", n},  int'(b), int'(m_run[i]));
    expect_eq({"done", n},  int'(d), int'(m_done[i]));
    expect_eq({"step", n},  int'(s), int'(m_step[i]));
    expect_eq({"wrap", n},  int'(w), int'(m_wrap[i]));
  endtask

  task automatic check_all();
    chk(0, int'(if0.count), if0.busy, if0.done, if0.step, if0.wrap);
    chk(1, int'(if1.count), if1.busy, if1.done, if1.step, if1.wrap);
    chk(2, int'(if2.count), if2.busy, if2.done, if2.step, if2.wrap);
    chk(3, int'(if3.count), if3.busy, if3.done, if3.step, if3.wrap);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cyc();
    @(posedge clk);
    if (resetn) for (int i = 0; i < 4; i++) medge(i);
    #1;
    check_all();
  endtask

  initial begin
    int steps;
    int k;
    bit seen;
    go = 0; up = 1; en = 0; abort = 0;
    resetn = 0;
    mreset();
    #12;
    check_all();                 // reset state
    cyc(); cyc();
    resetn = 1;

    // 1: count up 0..5 on A, done one tick after reaching 5
    up = 1; go = 1; cyc();
    go = 0; en = 1;
    steps = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      steps += int'(if0.step);
    end
    expect_eq("t1_steps", steps, 5);
    expect_eq("t1_count", int'(if0.count), 5);
    expect_eq("t1_done", int'(if0.done), 1);

    // 2: prescale by 4 on B with an enable gap mid-phase
    go = 1; cyc();
    go = 0; en = 1;
    for (int i = 0; i < 6; i++) cyc();
    en = 0;
    for (int i = 0; i < 3; i++) cyc();
    en = 1;
    for (int i = 0; i < 12; i++) cyc();

    // 3: count down with wrap on C
    up = 0; go = 1; cyc();
    go = 0; en = 1;
    for (int i = 0; i < 12; i++) cyc();

    // 4: abort at count 2, then go and abort together
    up = 1; go = 1; cyc();
    go = 0; en = 1;
    cyc(); cyc();
    abort = 1; cyc();
    abort = 0;
    for (int i = 0; i < 10; i++) cyc();
    expect_eq("t4_hold_count", int'(if0.count), 2);
    expect_eq("t4_hold_busy", int'(if0.busy), 0);
    go = 1; abort = 1; cyc();
    go = 0; abort = 0;
    expect_eq("t4_go_count", int'(if0.count), 0);
    expect_eq("t4_go_busy", int'(if0.busy), 1);

    // 5: go from DONE counting down, then async reset mid-cycle
    for (int i = 0; i < 8; i++) cyc();
    expect_eq("t5_pre_done", int'(if0.done), 1);
    up = 0; go = 1; cyc();
    go = 0;
    expect_eq("t5_count", int'(if0.count), 5);
    expect_eq("t5_done", int'(if0.done), 0);
    cyc(); cyc();
    #3;
    resetn = 0;
    mreset();
    #1;
    check_all();
    expect_eq("t5_rst_count", int'(if0.count), 0);
    cyc();
    resetn = 1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      go    = ($urandom_range(15) == 0);
      abort = ($urandom_range(15) == 0);
      en    = ($urandom_range(3) != 0);
      up    = $urandom_range(1);
      cyc();
    end

    // 6: full-range run on D
    abort = 0; up = 1; go = 1; cyc();
    go = 0; en = 1;
    seen = 0;
    k = 0;
    for (int i = 1; i <= 13000; i++) begin
      cyc();
      if (if3.done) begin
        k = i; seen = 1;
        break;
      end
    end
    expect_eq("t6_seen", int'(seen), 1);
    expect_eq("t6_cycles", k, 12349);
    expect_eq("t6_count", int'(if3.count), 12348);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
